// File: rtl/game_pkg.sv
// Shared definitions for the display side of the game.
//   - game state encoding (S_START..S_LOSE)
//   - 24-bit colour constants
//   - VGA 640x480@60 timing defaults and sprite box sizes
//   - snapshot structs and small hit-test helpers
package game_pkg;

  // Game state encoding as driven by the game controller
  localparam logic [1:0] S_START = 2'b00;
  localparam logic [1:0] S_PLAY  = 2'b01;
  localparam logic [1:0] S_WIN   = 2'b10;
  localparam logic [1:0] S_LOSE  = 2'b11;

  // Colours
  localparam logic [23:0] C_BAD_BULLET  = 24'hFF8000;
  localparam logic [23:0] C_GOOD_BULLET = 24'hFFFF00;
  localparam logic [23:0] C_SHIELD      = 24'hFFFFFF;
  localparam logic [23:0] C_PLAYER      = 24'h00FFFF;
  localparam logic [23:0] C_ENEMY       = 24'hFF00FF;
  localparam logic [23:0] C_PLAYER_HP   = 24'h00C000;
  localparam logic [23:0] C_ENEMY_HP    = 24'hC00000;
  localparam logic [23:0] C_BG_START    = 24'h000040;
  localparam logic [23:0] C_BG_PLAY     = 24'h000000;
  localparam logic [23:0] C_BG_WIN      = 24'h004000;
  localparam logic [23:0] C_BG_LOSE     = 24'h400000;

  // VGA timing defaults (640x480@60)
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Sprite and HUD geometry
  localparam int PLAYER_W = 32;
  localparam int PLAYER_H = 48;
  localparam int SQUAT_H  = 24;
  localparam int BULLET_W = 8;
  localparam int BULLET_H = 4;
  localparam int SHIELD_T = 2;
  localparam int BAR_Y0   = 8;
  localparam int BAR_Y1   = 16;
  localparam int BAR_X    = 16;

  typedef struct packed {
    logic signed [10:0] x;
    logic signed [9:0]  y;
    logic [1:0]         hp;
    logic               shield;
    logic               squat;
  } char_t;

  typedef struct packed {
    logic signed [10:0] x;
    logic signed [9:0]  y;
    logic               exists;
  } bullet_t;

  typedef struct packed {
    logic [1:0] state;
    char_t      player;
    char_t      enemy;
    bullet_t    good;
    bullet_t    bad;
  } scene_t;

  function automatic logic signed [11:0] sext_x(logic signed [10:0] x);
    return {x[10], x};
  endfunction

  function automatic logic signed [11:0] sext_y(logic signed [9:0] y);
    return {{2{y[9]}}, y};
  endfunction

  // p in [lo, lo+len), all signed 12-bit so off-screen boxes clip without wrap
  function automatic logic in_span(logic signed [11:0] p, logic signed [11:0] lo,
                                   logic [11:0] len);
    logic signed [11:0] hi;
    hi = lo + $signed(len);
    return (p >= lo) && (p < hi);
  endfunction

  function automatic logic [23:0] bg_colour(logic [1:0] s);
    logic [23:0] c;
    case (s)
      S_START: c = C_BG_START;
      S_PLAY:  c = C_BG_PLAY;
      S_WIN:   c = C_BG_WIN;
      default: c = C_BG_LOSE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster counters and raw (unpipelined) timing signals.
//   clk, rst   : clock, synchronous active-high reset
//   pix_en     : pixel-rate enable; counters advance only when high
//   hcnt, vcnt : current pixel position (0..H_TOTAL-1, 0..V_TOTAL-1)
//   de         : raw visible-area flag
//   hsync/vsync: raw active-low syncs
//   snap       : high on the pix_en cycle at hcnt=0, vcnt=V_ACTIVE
module vga_timing
  import game_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       de,
  output logic       hsync,
  output logic       vsync,
  output logic       snap
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      if (hcnt == 10'(H_TOTAL - 1)) begin
        hcnt <= '0;
        vcnt <= (vcnt == 10'(V_TOTAL - 1)) ? 10'd0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  assign de    = (hcnt < 10'(H_ACTIVE)) && (vcnt < 10'(V_ACTIVE));
  assign hsync = !((hcnt >= 10'(H_ACTIVE + H_FP)) && (hcnt < 10'(H_ACTIVE + H_FP + H_SYNC)));
  assign vsync = !((vcnt >= 10'(V_ACTIVE + V_FP)) && (vcnt < 10'(V_ACTIVE + V_FP + V_SYNC)));
  // First blanking pixel after the last visible line: safe point to latch game state
  assign snap  = pix_en && (hcnt == 10'd0) && (vcnt == 10'(V_ACTIVE));

endmodule

// File: rtl/scene_renderer.sv
// Composes VGA pixels from a per-frame snapshot of the game-state bus.
//   clk, rst        : clock, synchronous active-high reset
//   pix_en          : pixel-rate enable
//   i_state         : game state (START/PLAY/WIN/LOSE)
//   i_player_*, i_enemy_*       : character position, HP, shield, squat
//   i_goodbullet_*, i_badbullet_*: bullet position and existence
//   o_hsync, o_vsync: active-low syncs
//   o_de            : visible-area data enable
//   o_r, o_g, o_b   : pixel colour, zero outside the visible area
//   o_frame_start   : one-clk pulse after the snapshot is taken
// Outputs lag the raster counters by two pix_en ticks (hit stage, colour stage).
module scene_renderer
  import game_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic [1:0]        i_state,
  input  logic signed [10:0] i_player_x,
  input  logic signed [9:0] i_player_y,
  input  logic signed [10:0] i_enemy_x,
  input  logic signed [9:0] i_enemy_y,
  input  logic [1:0]        i_player_hp,
  input  logic [1:0]        i_enemy_hp,
  input  logic              i_player_shield,
  input  logic              i_enemy_shield,
  input  logic              i_player_squat,
  input  logic              i_enemy_squat,
  input  logic signed [10:0] i_goodbullet_x,
  input  logic signed [9:0] i_goodbullet_y,
  input  logic signed [10:0] i_badbullet_x,
  input  logic signed [9:0] i_badbullet_y,
  input  logic              i_goodbullet_isE,
  input  logic              i_badbullet_isE,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_de,
  output logic [7:0]        o_r,
  output logic [7:0]        o_g,
  output logic [7:0]        o_b,
  output logic              o_frame_start
);

  localparam logic signed [11:0] SQUAT_OFS = 12'(PLAYER_H - SQUAT_H);
  localparam logic signed [11:0] SHIELD_OFS = 12'(SHIELD_T);

  logic [9:0] hcnt, vcnt;
  logic       raw_de, raw_hsync, raw_vsync, snap;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk   (clk),
    .rst   (rst),
    .pix_en(pix_en),
    .hcnt  (hcnt),
    .vcnt  (vcnt),
    .de    (raw_de),
    .hsync (raw_hsync),
    .vsync (raw_vsync),
    .snap  (snap)
  );

  // ---------------- snapshot ----------------
  scene_t scene_in, shadow_reg;

  always_comb begin
    scene_in               = '0;
    scene_in.state         = i_state;
    scene_in.player.x      = i_player_x;
    scene_in.player.y      = i_player_y;
    scene_in.player.hp     = i_player_hp;
    scene_in.player.shield = i_player_shield;
    scene_in.player.squat  = i_player_squat;
    scene_in.enemy.x       = i_enemy_x;
    scene_in.enemy.y       = i_enemy_y;
    scene_in.enemy.hp      = i_enemy_hp;
    scene_in.enemy.shield  = i_enemy_shield;
    scene_in.enemy.squat   = i_enemy_squat;
    scene_in.good.x        = i_goodbullet_x;
    scene_in.good.y        = i_goodbullet_y;
    scene_in.good.exists   = i_goodbullet_isE;
    scene_in.bad.x         = i_badbullet_x;
    scene_in.bad.y         = i_badbullet_y;
    scene_in.bad.exists    = i_badbullet_isE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_reg           <= '0;
      shadow_reg.state     <= S_START;
      shadow_reg.player.hp <= 2'd3;
      shadow_reg.enemy.hp  <= 2'd3;
      o_frame_start        <= 1'b0;
    end else begin
      if (snap) shadow_reg <= scene_in;
      o_frame_start <= snap;
    end
  end

  // ---------------- hit test ----------------
  logic signed [11:0] px, py;
  assign px = $signed({2'b00, hcnt});
  assign py = $signed({2'b00, vcnt});

  char_t   chars   [2];
  bullet_t bullets [2];
  assign chars[0]   = shadow_reg.player;
  assign chars[1]   = shadow_reg.enemy;
  assign bullets[0] = shadow_reg.good;
  assign bullets[1] = shadow_reg.bad;

  logic [1:0] char_in, char_border, bullet_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_char
      logic signed [11:0] left, top;
      logic [11:0]        height;
      logic               inner;
      // A squatting character keeps its feet on the same line: top moves down
      assign left   = sext_x(chars[gi].x);
      assign top    = sext_y(chars[gi].y) + (chars[gi].squat ? SQUAT_OFS : 12'sd0);
      assign height = chars[gi].squat ? 12'(SQUAT_H) : 12'(PLAYER_H);
      assign char_in[gi] = in_span(px, left, 12'(PLAYER_W)) && in_span(py, top, height);
      assign inner  = in_span(px, left + SHIELD_OFS, 12'(PLAYER_W - 2 * SHIELD_T)) &&
                      in_span(py, top + SHIELD_OFS, height - 12'(2 * SHIELD_T));
      assign char_border[gi] = chars[gi].shield && char_in[gi] && !inner;
    end

    for (gi = 0; gi < 2; gi++) begin : g_bullet
      assign bullet_hit[gi] = bullets[gi].exists &&
                              in_span(px, sext_x(bullets[gi].x), 12'(BULLET_W)) &&
                              in_span(py, sext_y(bullets[gi].y), 12'(BULLET_H));
    end
  endgenerate

  // HP bars grow inward from each screen edge, 32 pixels per point
  logic       bar_row, php_hit, ehp_hit;
  logic [9:0] php_len, ehp_len, ebar_end;
  assign bar_row  = (vcnt >= 10'(BAR_Y0)) && (vcnt < 10'(BAR_Y1));
  assign php_len  = {3'b000, shadow_reg.player.hp, 5'b00000};
  assign ehp_len  = {3'b000, shadow_reg.enemy.hp, 5'b00000};
  assign ebar_end = 10'(H_ACTIVE - BAR_X);
  assign php_hit  = bar_row && (hcnt >= 10'(BAR_X)) && (hcnt < 10'(BAR_X) + php_len);
  assign ehp_hit  = bar_row && (hcnt >= ebar_end - ehp_len) && (hcnt < ebar_end);

  logic play;
  assign play = (shadow_reg.state == S_PLAY);

  // ---------------- stage 1: hit flags + raw timing ----------------
  logic       s1_de_reg, s1_hsync_reg, s1_vsync_reg;
  logic [1:0] s1_state_reg;
  logic       s1_bad_reg, s1_good_reg, s1_border_reg, s1_player_reg, s1_enemy_reg;
  logic       s1_php_reg, s1_ehp_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_de_reg     <= 1'b0;
      s1_hsync_reg  <= 1'b1;
      s1_vsync_reg  <= 1'b1;
      s1_state_reg  <= S_START;
      s1_bad_reg    <= 1'b0;
      s1_good_reg   <= 1'b0;
      s1_border_reg <= 1'b0;
      s1_player_reg <= 1'b0;
      s1_enemy_reg  <= 1'b0;
      s1_php_reg    <= 1'b0;
      s1_ehp_reg    <= 1'b0;
    end else if (pix_en) begin
      s1_de_reg     <= raw_de;
      s1_hsync_reg  <= raw_hsync;
      s1_vsync_reg  <= raw_vsync;
      s1_state_reg  <= shadow_reg.state;
      s1_bad_reg    <= play && bullet_hit[1];
      s1_good_reg   <= play && bullet_hit[0];
      s1_border_reg <= play && (|char_border);
      s1_player_reg <= play && char_in[0];
      s1_enemy_reg  <= play && char_in[1];
      s1_php_reg    <= play && php_hit;
      s1_ehp_reg    <= play && ehp_hit;
    end
  end

  // ---------------- stage 2: colour + delayed timing ----------------
  logic [23:0] colour_next, rgb_reg;

  always_comb begin
    colour_next = 24'h000000;
    if (s1_de_reg) begin
      if (s1_bad_reg)         colour_next = C_BAD_BULLET;
      else if (s1_good_reg)   colour_next = C_GOOD_BULLET;
      else if (s1_border_reg) colour_next = C_SHIELD;
      else if (s1_player_reg) colour_next = C_PLAYER;
      else if (s1_enemy_reg)  colour_next = C_ENEMY;
      else if (s1_php_reg)    colour_next = C_PLAYER_HP;
      else if (s1_ehp_reg)    colour_next = C_ENEMY_HP;
      else                    colour_next = bg_colour(s1_state_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_de    <= 1'b0;
      o_hsync <= 1'b1;
      o_vsync <= 1'b1;
      rgb_reg <= '0;
    end else if (pix_en) begin
      o_de    <= s1_de_reg;
      o_hsync <= s1_hsync_reg;
      o_vsync <= s1_vsync_reg;
      rgb_reg <= colour_next;
    end
  end

  assign o_r = rgb_reg[23:16];
  assign o_g = rgb_reg[15:8];
  assign o_b = rgb_reg[7:0];

endmodule

// File: doc/scene_renderer.md
# scene_renderer

Display-side consumer of the game-state bus driven by the game controller: generates 640x480@60 VGA timing and composes each pixel from a per-frame snapshot of state, player, enemy, bullets and HP. Sits between the game controller outputs and the VGA DAC pins. It also emits a once-per-frame pulse that the game logic uses as its tick.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch/sync widths
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch/sync widths
- PLAYER_W / PLAYER_H / SQUAT_H, 32 / 48 / 24, character box sizes (enemy identical)
- BULLET_W / BULLET_H, 8 / 4, bullet box size
- One clock; reset is synchronous and active-high.
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pix_en  in  1  pixel-rate enable (one cycle in N); all timing advances only when high
- i_state  in  2  00 START, 01 PLAY, 10 WIN, 11 LOSE
- i_player_x / i_enemy_x  in  11 signed  sprite left edge, screen pixels
- i_player_y / i_enemy_y  in  10 signed  sprite top edge
- i_player_hp / i_enemy_hp  in  2  HP, 0..3
- i_player_shield / i_enemy_shield, i_player_squat / i_enemy_squat  in  1 each
- i_goodbullet_x / i_badbullet_x  in  11 signed; i_goodbullet_y / i_badbullet_y  in  10 signed
- i_goodbullet_isE / i_badbullet_isE  in  1  bullet exists
- o_hsync / o_vsync  out  1  active-low sync
- o_de  out  1  data enable (visible area)
- o_r / o_g / o_b  out  8 each  pixel colour, 0 when o_de=0
- o_frame_start  out  1  one-clk pulse at snapshot

## Operation
- hcnt 0..799, vcnt 0..524; hcnt wraps on pix_en at 799, vcnt increments on that wrap, wraps 524->0.
- Visible: hcnt<640 && vcnt<480. hsync low for hcnt in [656,752); vsync low for vcnt in [490,492).
- Snapshot: on the pix_en cycle with hcnt=0, vcnt=480 all i_* are registered into a shadow set; o_frame_start pulses that clk. Shadow is constant for the whole next visible frame. Inputs changing mid-frame never tear.
- Hit test (signed 12-bit compare, counters zero-extended): sprite covers X in [x, x+W), Y in [y, y+H). Negative or >screen coordinates clip naturally; no wrap.
- Squat: box height SQUAT_H, top at y+PLAYER_H-SQUAT_H.
- Shield: 2-pixel border of the character box drawn white FFFFFF; interior keeps sprite colour.
- Bullets drawn only when isE=1.
- HP bars on y in [8,16): player x in [16, 16+32*hp); enemy x in [624-32*hp, 624). hp=0 draws nothing.
- Sprites and HP bars drawn only when shadow state = PLAY. Otherwise the whole visible area is background.
- Priority, high to low: badbullet FF8000, goodbullet FFFF00, shield border, player 00FFFF, enemy FF00FF, player HP 00C000, enemy HP C00000, background.
- Background colour: START 000040, PLAY 000000, WIN 004000, LOSE 400000.

## Timing
- 2-stage pixel pipeline, advancing only on pix_en. Stage 1 registers hit flags plus de/hsync/vsync. Stage 2 registers colour plus delayed syncs.
- Outputs lag the counters by exactly 2 pix_en ticks. Syncs, de and rgb remain mutually aligned.
- Outputs hold between pix_en pulses.
- Reset values:
  - counters 0
  - o_hsync=1, o_vsync=1, o_de=0, rgb=0, o_frame_start=0
  - pipeline registers cleared
  - shadow: state START, hp 3, positions 0, flags 0
- Reset asserted mid-frame: all of the above restored on the next clk edge. The first frame after reset renders the START background until the first snapshot.
- pix_en stuck low: everything frozen, o_frame_start stays 0.

## Structure
- game_pkg gains:
  - the state encoding constants (S_START..S_LOSE)
  - all colour constants as 24-bit localparams
  - VGA timing defaults
- Sub-module vga_timing: counters, raw sync/de, snapshot strobe. scene_renderer holds the shadow registers, hit test and pipeline.

## Test plan
- Reset, pix_en every 2nd clk, run 1 frame -> 800 pix_en per line, 525 lines; hsync low 96 ticks; vsync low 2 lines; o_de high 640x480; o_frame_start once per 420000 pix_en.
- State PLAY, player (100,200), no squat/shield -> pixel (100,200) and (131,247) = 00FFFF; (132,200) and (100,248) = background 000000.
- Player squat at y=200 -> (100,223) background, (100,224) 00FFFF. Shield=1 -> (101,230) FFFFFF, (110,230) 00FFFF.
- Overlap: badbullet and goodbullet both at (300,300), isE=1, over the enemy box -> (300,300) = FF8000. Set badbullet isE=0 -> FFFF00.
- Change i_player_x mid-frame (vcnt=200) -> rendering unchanged until after the vcnt=480 snapshot. Player x=-10 -> columns 0..21 drawn with no wrap artifacts at 630+.
- Clipping and bars: state WIN with sprites set -> all visible pixels 004000. player_hp=2 in PLAY -> (16..79, 8..15) 00C000, (80,8) background. Assert rst at vcnt=300 -> next clk outputs match the reset values.
